// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared constants, op encoding and FSM states for the register bank controller
package regbank_pkg;

    localparam int REGBANK_NREG = 8;
    localparam int REGBANK_DW   = 16;

    typedef enum logic [1:0] {
        REQ_NOP   = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2,
        REQ_RDWR  = 2'd3
    } req_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WSETUP  = 3'd1,
        ST_WSTROBE = 3'd2,
        ST_WHOLD   = 3'd3,
        ST_RD      = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

endpackage

// File: rtl/regbank_access_ctrl.sv
// rtl/regbank_access_ctrl.sv - request sequencer for the register bank (optional REGBANK_RDWR_BYPASS_EN: read-first RDWR with write-data bypass)
module regbank_access_ctrl
    import regbank_pkg::*;
#(
    parameter int NREG = REGBANK_NREG,
    parameter int DW   = REGBANK_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [$clog2(NREG)-1:0]  req_sel1,
    input  logic [$clog2(NREG)-1:0]  req_sel2,
    input  logic [$clog2(NREG)-1:0]  req_wsel,
    input  logic [DW-1:0]            req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_src1,
    output logic [DW-1:0]            rsp_src2,
    output logic                     wr_done,
    output logic                     bank_ce,
    output logic                     bank_rw,
    output logic [$clog2(NREG)-1:0]  bank_enable,
    output logic [$clog2(NREG)-1:0]  bank_sel1,
    output logic [$clog2(NREG)-1:0]  bank_sel2,
    output logic [DW-1:0]            bank_din,
    input  logic [DW-1:0]            bank_src1,
    input  logic [DW-1:0]            bank_src2
);

    localparam int SW = $clog2(NREG);

    state_e          state_q, state_d;
    req_op_e         op_q, op_d;
    logic [SW-1:0]   sel1_q, sel1_d;
    logic [SW-1:0]   sel2_q, sel2_d;
    logic [SW-1:0]   wsel_q, wsel_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rsp_src1_q, rsp_src1_d;
    logic [DW-1:0]   rsp_src2_q, rsp_src2_d;
    logic            rsp_pend_q, rsp_pend_d;

    logic            accept;
    logic [DW-1:0]   cap_src1;
    logic [DW-1:0]   cap_src2;

    assign accept = req_valid && (state_q == ST_IDLE);

    // Capture values for the response registers; the bypass replaces a bank read that
    // would see the pre-write contents of the register this RDWR is about to write.
`ifdef REGBANK_RDWR_BYPASS_EN
    assign cap_src1 = ((op_q == REQ_RDWR) && (sel1_q == wsel_q)) ? wdata_q : bank_src1;
    assign cap_src2 = ((op_q == REQ_RDWR) && (sel2_q == wsel_q)) ? wdata_q : bank_src2;
`else
    assign cap_src1 = bank_src1;
    assign cap_src2 = bank_src2;
`endif

    // State, latched request and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= REQ_NOP;
            sel1_q     <= '0;
            sel2_q     <= '0;
            wsel_q     <= '0;
            wdata_q    <= '0;
            rsp_src1_q <= '0;
            rsp_src2_q <= '0;
            rsp_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            wsel_q     <= wsel_d;
            wdata_q    <= wdata_d;
            rsp_src1_q <= rsp_src1_d;
            rsp_src2_q <= rsp_src2_d;
            rsp_pend_q <= rsp_pend_d;
        end
    end

    // Next-state sequencing through the write and read phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (req_op_e'(req_op))
                        REQ_READ:  state_d = ST_RD;
                        REQ_WRITE: state_d = ST_WSETUP;
`ifdef REGBANK_RDWR_BYPASS_EN
                        REQ_RDWR:  state_d = ST_RD;
`else
                        REQ_RDWR:  state_d = ST_WSETUP;
`endif
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WSETUP:  state_d = ST_WSTROBE;
            ST_WSTROBE: state_d = ST_WHOLD;
            ST_WHOLD: begin
`ifdef REGBANK_RDWR_BYPASS_EN
                // The read already happened; wait only if its response is still unclaimed.
                state_d = (rsp_pend_q && !rsp_ready) ? ST_RESP : ST_IDLE;
`else
                state_d = (op_q == REQ_RDWR) ? ST_RD : ST_IDLE;
`endif
            end
            ST_RD: begin
`ifdef REGBANK_RDWR_BYPASS_EN
                state_d = (op_q == REQ_RDWR) ? ST_WSETUP : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latching at accept, response capture in RD and response-pending tracking
    always_comb begin
        op_d       = op_q;
        sel1_d     = sel1_q;
        sel2_d     = sel2_q;
        wsel_d     = wsel_q;
        wdata_d    = wdata_q;
        rsp_src1_d = rsp_src1_q;
        rsp_src2_d = rsp_src2_q;
        rsp_pend_d = rsp_pend_q;
        if (accept) begin
            op_d    = req_op_e'(req_op);
            sel1_d  = req_sel1;
            sel2_d  = req_sel2;
            wsel_d  = req_wsel;
            wdata_d = req_wdata;
        end
        if (rsp_pend_q && rsp_ready) begin
            rsp_pend_d = 1'b0;
        end
        if (state_q == ST_RD) begin
            rsp_src1_d = cap_src1;
            rsp_src2_d = cap_src2;
            rsp_pend_d = 1'b1;
        end
    end

    // Bank strobes and handshake outputs decoded from the current state
    always_comb begin
        req_ready = 1'b0;
        bank_ce   = 1'b0;
        bank_rw   = 1'b1;
        wr_done   = 1'b0;
        case (state_q)
            ST_IDLE:    req_ready = 1'b1;
            ST_WSTROBE: begin
                bank_ce = 1'b1;
                bank_rw = 1'b0;
            end
            ST_WHOLD:   wr_done = 1'b1;
            ST_RD:      bank_ce = 1'b1;
            default:    ;
        endcase
    end

    assign rsp_valid   = rsp_pend_q;
    assign rsp_src1    = rsp_src1_q;
    assign rsp_src2    = rsp_src2_q;
    assign bank_enable = wsel_q;
    assign bank_din    = wdata_q;
    assign bank_sel1   = sel1_q;
    assign bank_sel2   = sel2_q;

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// tb/tb_regbank_access_ctrl.sv - directed self-checking bench for regbank_access_ctrl with a behavioural 8x16 bank
module tb_regbank_access_ctrl;
    import regbank_pkg::*;

`ifdef REGBANK_RDWR_BYPASS_EN
    localparam int RV_CYC   = 2;
    localparam int IDLE_CYC = 5;
`else
    localparam int RV_CYC   = 5;
    localparam int IDLE_CYC = 6;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_sel1, req_sel2, req_wsel;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_src1, rsp_src2;
    logic        wr_done;
    logic        bank_ce, bank_rw;
    logic [2:0]  bank_enable, bank_sel1, bank_sel2;
    logic [15:0] bank_din;
    logic [15:0] bank_src1, bank_src2;

    logic [15:0] mem [8];

    int n_pass  = 0;
    int n_total = 0;
    int c;

    always #5 clk = ~clk;

    regbank_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_sel1(req_sel1), .req_sel2(req_sel2), .req_wsel(req_wsel), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src1(rsp_src1), .rsp_src2(rsp_src2),
        .wr_done(wr_done), .bank_ce(bank_ce), .bank_rw(bank_rw),
        .bank_enable(bank_enable), .bank_sel1(bank_sel1), .bank_sel2(bank_sel2),
        .bank_din(bank_din), .bank_src1(bank_src1), .bank_src2(bank_src2)
    );

    // Bank model: write lands while strobed, reads return a recognisable junk value when disabled
    always @(posedge clk) begin
        if (bank_ce && !bank_rw) mem[bank_enable] <= bank_din;
    end
    assign bank_src1 = bank_ce ? mem[bank_sel1] : 16'hDEAD;
    assign bank_src2 = bank_ce ? mem[bank_sel2] : 16'hDEAD;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits (bounded) for req_ready, then steps through the accept edge
    task automatic send(input logic [1:0] op, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [2:0] ws, input logic [15:0] wd);
        int w;
        req_valid = 1'b1;
        req_op    = op;
        req_sel1  = s1;
        req_sel2  = s2;
        req_wsel  = ws;
        req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        if (!req_ready) chk("send_ready_timeout", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] ws, input logic [15:0] wd);
        send(REQ_WRITE, 3'd0, 3'd0, ws, wd);
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_sel1  = 3'd0;
        req_sel2  = 3'd0;
        req_wsel  = 3'd0;
        req_wdata = 16'h0;
        rsp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ctrl", {req_ready, rsp_valid, wr_done, bank_ce, bank_rw}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("rst_addr", {bank_enable, bank_sel1, bank_sel2, bank_din}, 64'h0);
        chk("rst_rsp", {rsp_src1, rsp_src2}, 64'h0);

        // WRITE R3 <- BEEF, cycle by cycle
        send(REQ_WRITE, 3'd0, 3'd0, 3'd3, 16'hBEEF);
        chk("wr_c1", {bank_ce, bank_rw, wr_done, req_ready, bank_enable, bank_din}, {4'b0100, 3'd3, 16'hBEEF});
        tick();
        chk("wr_c2", {bank_ce, bank_rw, wr_done, req_ready, bank_enable, bank_din}, {4'b1000, 3'd3, 16'hBEEF});
        tick();
        chk("wr_c3", {bank_ce, bank_rw, wr_done, req_ready, bank_enable, bank_din}, {4'b0110, 3'd3, 16'hBEEF});
        tick();
        chk("wr_c4", {bank_ce, bank_rw, wr_done, req_ready}, 4'b0101);

        // Preload R1, R6, R0
        do_write(3'd1, 16'h1111);
        do_write(3'd6, 16'h6666);
        do_write(3'd0, 16'h0001);

        // READ sel1=1 sel2=6 with consumer ready
        send(REQ_READ, 3'd1, 3'd6, 3'd0, 16'h0);
        chk("rd_c1", {bank_ce, bank_rw, rsp_valid, req_ready, bank_sel1, bank_sel2}, {4'b1100, 3'd1, 3'd6});
        tick();
        chk("rd_c2", {rsp_valid, bank_ce, rsp_src1, rsp_src2}, {2'b10, 16'h1111, 16'h6666});
        tick();
        chk("rd_c3", {req_ready, rsp_valid}, 2'b10);

        // READ under backpressure for 10 cycles
        rsp_ready = 1'b0;
        send(REQ_READ, 3'd3, 3'd1, 3'd0, 16'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold_%0d", i), {rsp_valid, req_ready, bank_ce, rsp_src1, rsp_src2},
                {3'b100, 16'hBEEF, 16'h1111});
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release", {req_ready, rsp_valid, bank_ce}, 3'b100);
        tick();
        chk("bp_single", {req_ready, rsp_valid}, 2'b10);

        // RDWR wsel=2 wdata=00A5 sel1=2 sel2=0
        send(REQ_RDWR, 3'd2, 3'd0, 3'd2, 16'h00A5);
        c = 1;
        while (!rsp_valid && c < 20) begin
            tick();
            c++;
        end
        chk("rdwr_rv_cycle", 64'(c), 64'(RV_CYC));
        chk("rdwr_data", {rsp_src1, rsp_src2}, {16'h00A5, 16'h0001});
        while (!req_ready && c < 30) begin
            tick();
            c++;
        end
        chk("rdwr_idle_cycle", 64'(c), 64'(IDLE_CYC));
        chk("rdwr_idle_rv", 64'(rsp_valid), 64'd0);

        // R2 must now hold the written value
        send(REQ_READ, 3'd2, 3'd3, 3'd0, 16'h0);
        tick();
        chk("rdwr_landed", {rsp_valid, rsp_src1, rsp_src2}, {1'b1, 16'h00A5, 16'hBEEF});
        tick();

        // Reset during WSTROBE
        send(REQ_WRITE, 3'd0, 3'd0, 3'd5, 16'h1234);
        tick();
        chk("rst_ws_pre", {bank_ce, bank_rw}, 2'b10);
        reset = 1'b1;
        tick();
        chk("rst_ws_post", {req_ready, rsp_valid, wr_done, bank_ce, bank_rw}, 5'b10001);
        reset = 1'b0;
        tick();
        chk("rst_ws_idle", {req_ready, bank_ce}, 2'b10);

        // Reset discards a pending response
        rsp_ready = 1'b0;
        send(REQ_READ, 3'd1, 3'd1, 3'd0, 16'h0);
        tick();
        chk("rst_rsp_pre", 64'(rsp_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_rsp_post", {req_ready, rsp_valid, rsp_src1}, {2'b10, 16'h0000});
        rsp_ready = 1'b1;
        tick();

        // Back-to-back WRITE R7 then READ R7 with req_valid held high
        req_valid = 1'b1;
        req_op    = REQ_WRITE;
        req_wsel  = 3'd7;
        req_wdata = 16'h7777;
        req_sel1  = 3'd0;
        req_sel2  = 3'd0;
        chk("b2b_c0_ready", 64'(req_ready), 64'd1);
        tick();
        req_op    = REQ_READ;
        req_sel1  = 3'd7;
        req_sel2  = 3'd3;
        req_wsel  = 3'd4;
        req_wdata = 16'h0BAD;
        chk("b2b_c1", {req_ready, bank_enable, bank_din}, {1'b0, 3'd7, 16'h7777});
        tick();
        tick();
        chk("b2b_c3", {req_ready, wr_done, bank_enable, bank_din}, {2'b01, 3'd7, 16'h7777});
        tick();
        chk("b2b_c4_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk("b2b_c5_rd", {bank_ce, bank_rw, bank_sel1, bank_sel2}, {2'b11, 3'd7, 3'd3});
        tick();
        chk("b2b_rsp", {rsp_valid, rsp_src1, rsp_src2}, {1'b1, 16'h7777, 16'hBEEF});
        tick();
        chk("b2b_done", {req_ready, rsp_valid}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regbank_access_ctrl.md
# regbank_access_ctrl

Sequencing master for the 8×16 register bank. It takes read, write and read-then-write requests from the control unit over a valid/ready handshake and drives the bank's chip-enable, read/write, select and data lines. Writes follow a setup/strobe/hold sequence so the bank's level-sensitive write never sees a changing address or data. Read results are registered and returned over a valid/ready response channel. It sits between the decode/control FSM and the register bank.

## Interface
- `NREG`, default 8: number of bank registers. Select width is log2(NREG).
- `DW`, default 16: data width.
- `clk`, in, 1: sole clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: the controller accepts a request this cycle.
- `req_op`, in, 2: request type.
  - 0 = NOP (accepted and dropped).
  - 1 = READ.
  - 2 = WRITE.
  - 3 = RDWR (write, then read both sources).
- `req_sel1`, in, 3: source 1 register select.
- `req_sel2`, in, 3: source 2 register select.
- `req_wsel`, in, 3: write register select.
- `req_wdata`, in, DW: write data.
- `rsp_valid`, out, 1: read data available.
- `rsp_ready`, in, 1: consumer takes the response.
- `rsp_src1`, out, DW: registered source 1 read data.
- `rsp_src2`, out, DW: registered source 2 read data.
- `wr_done`, out, 1: one-cycle pulse when a write completes.
- `bank_ce`, out, 1: bank chip enable.
- `bank_rw`, out, 1: bank read/write; 1 = read, 0 = write.
- `bank_enable`, out, 3: bank write address.
- `bank_sel1`, out, 3: bank read address, port 1.
- `bank_sel2`, out, 3: bank read address, port 2.
- `bank_din`, out, DW: bank write data.
- `bank_src1`, in, DW: bank read data, port 1 (Z when `bank_ce`=0).
- `bank_src2`, in, DW: bank read data, port 2 (Z when `bank_ce`=0).

## Operation
- **Request capture**
  - A request is accepted on any edge where `req_valid` && `req_ready`.
  - All request fields are latched into internal registers at acceptance.
  - Bank address and data lines are driven only from these latched registers.
- **FSM states:** IDLE, WSETUP, WSTROBE, WHOLD, RD, RESP.
- **IDLE**
  - `req_ready`=1, `bank_ce`=0, `bank_rw`=1.
  - On accept: READ → RD; WRITE or RDWR → WSETUP; NOP → IDLE.
- **WSETUP:** `bank_ce`=0, `bank_rw`=1; `bank_enable` and `bank_din` driven from the latched request.
- **WSTROBE:** `bank_ce`=1, `bank_rw`=0, with the same address and data.
- **WHOLD**
  - `bank_ce`=0, `bank_rw`=1; address and data held unchanged.
  - `wr_done`=1 for this cycle.
  - Next state: RDWR → RD; WRITE → IDLE.
- **RD**
  - `bank_ce`=1, `bank_rw`=1; `bank_sel1` and `bank_sel2` driven.
  - `bank_src1` and `bank_src2` are registered into `rsp_src1` and `rsp_src2` at the end of the cycle.
  - Next state: RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_src1` and `rsp_src2` stay stable until `rsp_valid` && `rsp_ready`.
  - On that handshake → IDLE.
- `req_ready` is 0 in every state other than IDLE, so there is never more than one request in flight.
- **Reset values:** state=IDLE; `req_ready`=1; `rsp_valid`=0; `wr_done`=0; `bank_ce`=0; `bank_rw`=1; all other outputs 0.
- **Reset mid-operation:** on the reset edge, go to IDLE with `bank_ce`=0 and `bank_rw`=1.
  - If reset lands in WSTROBE, the strobe ends; the write may or may not have landed.
  - A pending response is discarded.
- `rsp_src1` and `rsp_src2` load only in RD, so Z from a disabled bank is never captured.

## Timing
Cycle 0 is the accept edge.
- **READ**
  - RD in cycle 1; `rsp_valid` from cycle 2.
  - If `rsp_ready` is already high in cycle 2, `req_ready` returns in cycle 3.
- **WRITE**
  - WSETUP in cycle 1, WSTROBE in cycle 2.
  - WHOLD in cycle 3, with `wr_done` pulsing in cycle 3.
  - `req_ready` returns in cycle 4.
- **RDWR (baseline)**
  - Write phases in cycles 1–3, RD in cycle 4.
  - `rsp_valid` from cycle 5; a read of `req_wsel` returns the new data.
- **Response backpressure:** holding `rsp_ready` low stalls in RESP indefinitely, with no bank activity.

## Configuration
- **`REGBANK_RDWR_BYPASS_EN` undefined:** RDWR follows the baseline order above.
- **`REGBANK_RDWR_BYPASS_EN` defined:** RDWR runs RD first (cycle 1), then WSETUP, WSTROBE, WHOLD (cycles 2–4).
  - `rsp_valid` rises in cycle 2 and can be consumed while the write proceeds.
  - At capture, a source whose select equals `req_wsel` takes `req_wdata` instead of the bank value.
  - The controller returns to IDLE only after WHOLD has completed and the response has been taken.

## Structure
- **Shared package `regbank_pkg`:**
  - Op encoding enum: `REQ_NOP`, `REQ_READ`, `REQ_WRITE`, `REQ_RDWR`.
  - FSM state enum.
  - `REGBANK_NREG` and `REGBANK_DW` constants.
- **Sub-module:** none required. The optional bypass mux is inline.

## Test plan
- Write R3 ← 0xBEEF: `bank_rw`=0 only in cycle 2, with `bank_enable`=3 and `bank_din`=0xBEEF held in cycles 1–3; `wr_done` pulses in cycle 3.
- Preload R1=0x1111 and R6=0x6666, then READ with sel1=1, sel2=6: `rsp_valid` in cycle 2 with `rsp_src1`=0x1111 and `rsp_src2`=0x6666.
- READ with `rsp_ready` held low for 10 cycles: `rsp_valid` and data stay stable, `req_ready`=0 and `bank_ce`=0 throughout; a single handshake then returns to IDLE.
- RDWR with wsel=2, wdata=0x00A5, sel1=2, sel2=0 (R0=0x0001):
  - Response is src1=0x00A5, src2=0x0001 in both configurations.
  - `rsp_valid` appears in cycle 5 without the macro and in cycle 2 with it.
- Reset asserted during WSTROBE: the next cycle shows IDLE, `bank_ce`=0, `bank_rw`=1, `req_ready`=1, `rsp_valid`=0.
- Back-to-back WRITE then READ of the same register, with `req_valid` held high: the READ is accepted in cycle 4 and returns the written value.
